// File: rtl/rs_iss_arb_pkg.sv
// Shared widths, the "no functional unit" encoding and the issue-packet layout
// used by the issue register and the execute-stage input.
package rs_iss_arb_pkg;

  localparam int PRF_IDX_W = 6;
  localparam int ROB_IDX_W = 5;
  localparam int BR_MASK_W = 4;
  localparam int FU_SEL_W  = 3;

  localparam logic [FU_SEL_W-1:0] FU_SEL_NONE = '0;

  typedef struct packed {
    logic [PRF_IDX_W-1:0] opa;
    logic [PRF_IDX_W-1:0] opb;
    logic [PRF_IDX_W-1:0] dest;
    logic [FU_SEL_W-1:0]  fu_sel;
    logic [31:0]          IR;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [BR_MASK_W-1:0] br_mask;
  } iss_pkt_t;

  localparam iss_pkt_t ISS_PKT_RESET = '{fu_sel: FU_SEL_NONE, default: '0};

endpackage

// File: rtl/rs_iss_arb_rr.sv
// Combinational round-robin picker: lowest requester at or above ptr, else wraps
// to the lowest requester below ptr. The caller owns the pointer register.
module rr_arb #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    // N is a power of two, so the IW-bit add wraps exactly at N
    for (int i = 0; i < N; i++) begin
      idx = ptr + IW'(i);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    any = found;
    if (found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/rs_iss_arb.sv
// Issue arbiter plus single issue register between the reservation station and
// the execute stage, with branch-mask clearing and misprediction squash.
module rs_iss_arb
  import rs_iss_arb_pkg::*;
#(
  parameter int RS_ENT_NUM = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [RS_ENT_NUM-1:0]           ent_rdy_i,
  input  logic [RS_ENT_NUM*FU_SEL_W-1:0]  ent_fu_sel_i,
  input  logic [RS_ENT_NUM*PRF_IDX_W-1:0] ent_opa_tag_i,
  input  logic [RS_ENT_NUM*PRF_IDX_W-1:0] ent_opb_tag_i,
  input  logic [RS_ENT_NUM*PRF_IDX_W-1:0] ent_dest_tag_i,
  input  logic [RS_ENT_NUM*32-1:0]        ent_IR_i,
  input  logic [RS_ENT_NUM*ROB_IDX_W-1:0] ent_rob_idx_i,
  input  logic [RS_ENT_NUM*BR_MASK_W-1:0] ent_br_mask_i,
  output logic [RS_ENT_NUM-1:0]           ent_iss_en_o,
  input  logic                            br_pred_correct_i,
  input  logic                            br_recovery_i,
  input  logic [BR_MASK_W-1:0]            br_tag_fix_i,
  input  logic                            fu_rdy_i,
  output logic                            iss_vld_o,
  output logic [PRF_IDX_W-1:0]            iss_opa_tag_o,
  output logic [PRF_IDX_W-1:0]            iss_opb_tag_o,
  output logic [PRF_IDX_W-1:0]            iss_dest_tag_o,
  output logic [FU_SEL_W-1:0]             iss_fu_sel_o,
  output logic [31:0]                     iss_IR_o,
  output logic [ROB_IDX_W-1:0]            iss_rob_idx_o,
  output logic [BR_MASK_W-1:0]            iss_br_mask_o
);

  localparam int IW = $clog2(RS_ENT_NUM);

  iss_pkt_t                ent [RS_ENT_NUM];
  iss_pkt_t                iss_r;
  logic                    iss_vld_r;
  logic [IW-1:0]           rr_ptr;
  logic [RS_ENT_NUM-1:0]   ent_kill;
  logic [RS_ENT_NUM-1:0]   cand;
  logic [RS_ENT_NUM-1:0]   gnt;
  logic [IW-1:0]           gnt_idx;
  logic                    any;
  logic                    hold_kill;
  logic                    load_en;
  logic                    do_grant;
  logic                    mask_clr;

  always_comb begin
    for (int i = 0; i < RS_ENT_NUM; i++) begin
      ent[i] = '{opa:     ent_opa_tag_i[i*PRF_IDX_W +: PRF_IDX_W],
                 opb:     ent_opb_tag_i[i*PRF_IDX_W +: PRF_IDX_W],
                 dest:    ent_dest_tag_i[i*PRF_IDX_W +: PRF_IDX_W],
                 fu_sel:  ent_fu_sel_i[i*FU_SEL_W +: FU_SEL_W],
                 IR:      ent_IR_i[i*32 +: 32],
                 rob_idx: ent_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W],
                 br_mask: ent_br_mask_i[i*BR_MASK_W +: BR_MASK_W]};
      ent_kill[i] = br_recovery_i & |(ent[i].br_mask & br_tag_fix_i);
      cand[i]     = ent_rdy_i[i] & ~ent_kill[i] & (ent[i].fu_sel != FU_SEL_NONE);
    end
  end

  rr_arb #(.N(RS_ENT_NUM), .IW(IW)) u_rr (
    .req     (cand),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Recovery wins over a simultaneous (illegal) correct prediction
  assign mask_clr     = br_pred_correct_i & ~br_recovery_i;
  assign hold_kill    = br_recovery_i & iss_vld_r & |(iss_r.br_mask & br_tag_fix_i);
  assign load_en      = ~iss_vld_r | fu_rdy_i | hold_kill;
  assign do_grant     = load_en & any & ~rst;
  assign ent_iss_en_o = do_grant ? gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_vld_r <= 1'b0;
      iss_r     <= ISS_PKT_RESET;
      rr_ptr    <= '0;
    end else if (do_grant) begin
      iss_vld_r <= 1'b1;
      iss_r     <= ent[gnt_idx];
      rr_ptr    <= gnt_idx + IW'(1);
    end else if (load_en) begin
      iss_vld_r <= 1'b0;
      iss_r     <= ISS_PKT_RESET;
    end else if (mask_clr) begin
      iss_r.br_mask <= iss_r.br_mask & ~br_tag_fix_i;
    end
  end

  assign iss_vld_o      = iss_vld_r & ~hold_kill;
  assign iss_opa_tag_o  = iss_r.opa;
  assign iss_opb_tag_o  = iss_r.opb;
  assign iss_dest_tag_o = iss_r.dest;
  assign iss_fu_sel_o   = iss_r.fu_sel;
  assign iss_IR_o       = iss_r.IR;
  assign iss_rob_idx_o  = iss_r.rob_idx;
  assign iss_br_mask_o  = mask_clr ? (iss_r.br_mask & ~br_tag_fix_i) : iss_r.br_mask;

endmodule

// File: tb/tb_rs_iss_arb.sv
// Randomized + directed bench: a reference model predicts grants and the held
// instruction; issued packets go through a scoreboard queue checked by a monitor.
module tb_rs_iss_arb;
  import rs_iss_arb_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]           ent_rdy_i = '0;
  logic [N*FU_SEL_W-1:0]  ent_fu_sel_i = '0;
  logic [N*PRF_IDX_W-1:0] ent_opa_tag_i = '0;
  logic [N*PRF_IDX_W-1:0] ent_opb_tag_i = '0;
  logic [N*PRF_IDX_W-1:0] ent_dest_tag_i = '0;
  logic [N*32-1:0]        ent_IR_i = '0;
  logic [N*ROB_IDX_W-1:0] ent_rob_idx_i = '0;
  logic [N*BR_MASK_W-1:0] ent_br_mask_i = '0;
  logic [N-1:0]           ent_iss_en_o;
  logic                   br_pred_correct_i = 1'b0;
  logic                   br_recovery_i = 1'b0;
  logic [BR_MASK_W-1:0]   br_tag_fix_i = '0;
  logic                   fu_rdy_i = 1'b0;
  logic                   iss_vld_o;
  logic [PRF_IDX_W-1:0]   iss_opa_tag_o, iss_opb_tag_o, iss_dest_tag_o;
  logic [FU_SEL_W-1:0]    iss_fu_sel_o;
  logic [31:0]            iss_IR_o;
  logic [ROB_IDX_W-1:0]   iss_rob_idx_o;
  logic [BR_MASK_W-1:0]   iss_br_mask_o;

  rs_iss_arb #(.RS_ENT_NUM(N)) dut (
    .clk(clk), .rst(rst),
    .ent_rdy_i(ent_rdy_i), .ent_fu_sel_i(ent_fu_sel_i),
    .ent_opa_tag_i(ent_opa_tag_i), .ent_opb_tag_i(ent_opb_tag_i),
    .ent_dest_tag_i(ent_dest_tag_i), .ent_IR_i(ent_IR_i),
    .ent_rob_idx_i(ent_rob_idx_i), .ent_br_mask_i(ent_br_mask_i),
    .ent_iss_en_o(ent_iss_en_o),
    .br_pred_correct_i(br_pred_correct_i), .br_recovery_i(br_recovery_i),
    .br_tag_fix_i(br_tag_fix_i), .fu_rdy_i(fu_rdy_i),
    .iss_vld_o(iss_vld_o), .iss_opa_tag_o(iss_opa_tag_o),
    .iss_opb_tag_o(iss_opb_tag_o), .iss_dest_tag_o(iss_dest_tag_o),
    .iss_fu_sel_o(iss_fu_sel_o), .iss_IR_o(iss_IR_o),
    .iss_rob_idx_o(iss_rob_idx_o), .iss_br_mask_o(iss_br_mask_o)
  );

  int checks = 0;
  int failures = 0;

  // staged stimulus for the next cycle
  logic [N-1:0]         st_rdy;
  iss_pkt_t             st_ent [N];
  logic                 st_pc, st_rec, st_fu_rdy, st_rst;
  logic [BR_MASK_W-1:0] st_tag;

  // reference model state
  logic     m_vld = 1'b0;
  iss_pkt_t m_pkt;
  int       m_ptr = 0;
  iss_pkt_t exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic clear_stim();
    st_rdy = '0; st_pc = 1'b0; st_rec = 1'b0; st_fu_rdy = 1'b1; st_rst = 1'b0; st_tag = '0;
    for (int i = 0; i < N; i++) begin
      st_ent[i].opa     = PRF_IDX_W'($urandom);
      st_ent[i].opb     = PRF_IDX_W'($urandom);
      st_ent[i].dest    = PRF_IDX_W'($urandom);
      st_ent[i].fu_sel  = FU_SEL_W'($urandom_range(1, 7));
      st_ent[i].IR      = $urandom;
      st_ent[i].rob_idx = ROB_IDX_W'($urandom);
      st_ent[i].br_mask = '0;
    end
  endtask

  task automatic rand_stim();
    int r;
    clear_stim();
    st_rdy = N'($urandom);
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 3) == 0) st_ent[i].fu_sel = FU_SEL_NONE;
      st_ent[i].br_mask = BR_MASK_W'($urandom & $urandom);
    end
    r = $urandom_range(0, 15);
    st_rec = (r < 2) || (r == 15);
    st_pc  = (r >= 2 && r < 5) || (r == 15);
    st_tag = BR_MASK_W'(1) << $urandom_range(0, BR_MASK_W - 1);
    st_fu_rdy = ($urandom_range(0, 9) < 6);
    if ($urandom_range(0, 199) == 0) begin
      st_rst = 1'b1;
      st_fu_rdy = 1'b0;
    end
  endtask

  task automatic run_cycle();
    int g;
    int idx;
    logic kill, load;
    logic [N-1:0] exp_gnt;
    logic [BR_MASK_W-1:0] exp_mask;
    iss_pkt_t tmp;
    @(negedge clk);
    rst = st_rst; ent_rdy_i = st_rdy; fu_rdy_i = st_fu_rdy;
    br_pred_correct_i = st_pc; br_recovery_i = st_rec; br_tag_fix_i = st_tag;
    for (int i = 0; i < N; i++) begin
      ent_fu_sel_i[i*FU_SEL_W +: FU_SEL_W]     = st_ent[i].fu_sel;
      ent_opa_tag_i[i*PRF_IDX_W +: PRF_IDX_W]  = st_ent[i].opa;
      ent_opb_tag_i[i*PRF_IDX_W +: PRF_IDX_W]  = st_ent[i].opb;
      ent_dest_tag_i[i*PRF_IDX_W +: PRF_IDX_W] = st_ent[i].dest;
      ent_IR_i[i*32 +: 32]                     = st_ent[i].IR;
      ent_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W]  = st_ent[i].rob_idx;
      ent_br_mask_i[i*BR_MASK_W +: BR_MASK_W]  = st_ent[i].br_mask;
    end
    #1;
    kill = st_rec && m_vld && ((m_pkt.br_mask & st_tag) != 0);
    load = !m_vld || st_fu_rdy || kill;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && st_rdy[idx] && st_ent[idx].fu_sel != FU_SEL_NONE &&
          !(st_rec && ((st_ent[idx].br_mask & st_tag) != 0)))
        g = idx;
    end
    if (st_rst || !load) g = -1;
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    chk("grant", ent_iss_en_o, exp_gnt);
    if (!st_rst) begin
      chk("iss_vld", iss_vld_o, m_vld && !kill);
      if (m_vld && !kill) begin
        exp_mask = (st_pc && !st_rec) ? (m_pkt.br_mask & ~st_tag) : m_pkt.br_mask;
        chk("held_ir", iss_IR_o, m_pkt.IR);
        chk("held_mask", iss_br_mask_o, exp_mask);
      end
    end
    #2;
    if (st_rst) begin
      m_vld = 1'b0; m_ptr = 0; exp_q.delete();
    end else begin
      if (kill && exp_q.size() > 0) void'(exp_q.pop_back());
      if (g >= 0) begin
        m_vld = 1'b1; m_pkt = st_ent[g]; m_ptr = (g + 1) % N;
        exp_q.push_back(st_ent[g]);
      end else if (load) begin
        m_vld = 1'b0;
      end else if (st_pc && !st_rec) begin
        m_pkt.br_mask = m_pkt.br_mask & ~st_tag;
        if (exp_q.size() > 0) begin
          tmp = exp_q[exp_q.size() - 1];
          tmp.br_mask = tmp.br_mask & ~st_tag;
          exp_q[exp_q.size() - 1] = tmp;
        end
      end
    end
  endtask

  // monitor: every accepted issue must match the oldest expected packet
  iss_pkt_t e;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (iss_vld_o && fu_rdy_i && !rst) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL issue_unexpected actual=IR %0h required=no issue", iss_IR_o);
        end else begin
          e = exp_q.pop_front();
          if (br_pred_correct_i && !br_recovery_i) e.br_mask = e.br_mask & ~br_tag_fix_i;
          chk("iss_opa", iss_opa_tag_o, e.opa);
          chk("iss_opb", iss_opb_tag_o, e.opb);
          chk("iss_dest", iss_dest_tag_o, e.dest);
          chk("iss_fu_sel", iss_fu_sel_o, e.fu_sel);
          chk("iss_ir", iss_IR_o, e.IR);
          chk("iss_rob", iss_rob_idx_o, e.rob_idx);
          chk("iss_mask", iss_br_mask_o, e.br_mask);
        end
      end
    end
  end

  initial begin
    clear_stim();
    st_rst = 1'b1; st_fu_rdy = 1'b0;
    run_cycle();
    run_cycle();
    clear_stim();
    #1;
    chk("rst_vld", iss_vld_o, 1'b0);
    chk("rst_fu_sel", iss_fu_sel_o, FU_SEL_NONE);
    chk("rst_ir", iss_IR_o, 32'h0);
    chk("rst_mask", iss_br_mask_o, 4'h0);
    chk("rst_gnt", ent_iss_en_o, 8'h0);

    // round-robin basics and wrap
    st_rdy = 8'b0010_0100; run_cycle(); run_cycle();
    st_rdy = 8'b0000_0011; run_cycle();
    // stall with everything ready, then release
    st_rdy = 8'hFF; st_fu_rdy = 1'b0;
    repeat (3) run_cycle();
    st_fu_rdy = 1'b1; run_cycle();

    // held mask 0110 cleared by a correct prediction while stalled
    clear_stim(); st_rdy = 8'b0100_0000; st_ent[6].br_mask = 4'b0110; run_cycle();
    clear_stim(); st_fu_rdy = 1'b0; st_pc = 1'b1; st_tag = 4'b0010; run_cycle();
    clear_stim(); st_fu_rdy = 1'b0; run_cycle();
    // squash of held 0100 while entry 3 is issued in its place
    clear_stim(); st_fu_rdy = 1'b0; st_rec = 1'b1; st_tag = 4'b0100;
    st_rdy = 8'b0000_1000; st_ent[3].br_mask = 4'b0001; run_cycle();
    clear_stim(); st_fu_rdy = 1'b0; run_cycle();
    // killed entry 0 skipped, entry 1 granted
    clear_stim(); st_rec = 1'b1; st_tag = 4'b1000; st_rdy = 8'b0000_0011;
    st_ent[0].br_mask = 4'b1000; run_cycle();

    repeat (3000) begin
      rand_stim();
      run_cycle();
    end

    clear_stim();
    repeat (3) run_cycle();
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_iss_arb.md
Name: rs_iss_arb

Overview:
Issue arbiter and issue-stage pipeline register directly downstream of the reservation-station entries.
- Each cycle it picks one ready entry using round-robin and pulses that entry's issue-enable, which frees the entry on the next clock.
- It latches the picked instruction into a single issue register that feeds the execute stage through a valid/ready handshake.
- It applies branch-mask clearing and branch-misprediction squash to the held instruction.

Parameters:
RS_ENT_NUM, 8, number of RS entries arbitrated (power of two, >=2)
PRF_IDX_W, 6, physical register tag width
ROB_IDX_W, 5, ROB index width
BR_MASK_W, 4, branch mask width
FU_SEL_W, 3, functional-unit select width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ent_rdy_i  in  RS_ENT_NUM  per-entry ready (both operands available, entry occupied)
ent_fu_sel_i  in  RS_ENT_NUM*FU_SEL_W  per-entry FU select, entry i at slice i
ent_opa_tag_i  in  RS_ENT_NUM*PRF_IDX_W  per-entry operand A tag
ent_opb_tag_i  in  RS_ENT_NUM*PRF_IDX_W  per-entry operand B tag
ent_dest_tag_i  in  RS_ENT_NUM*PRF_IDX_W  per-entry destination tag
ent_IR_i  in  RS_ENT_NUM*32  per-entry instruction word
ent_rob_idx_i  in  RS_ENT_NUM*ROB_IDX_W  per-entry ROB index
ent_br_mask_i  in  RS_ENT_NUM*BR_MASK_W  per-entry branch mask, already corrected for this cycle's correct prediction
ent_iss_en_o  out  RS_ENT_NUM  one-hot grant; drives the entry's issue-enable
br_pred_correct_i  in  1  branch resolved correctly this cycle
br_recovery_i  in  1  branch mispredicted this cycle
br_tag_fix_i  in  BR_MASK_W  one-hot tag of the resolving branch
fu_rdy_i  in  1  execute stage accepts the issue register this cycle
iss_vld_o  out  1  issue register holds a live instruction
iss_opa_tag_o / iss_opb_tag_o / iss_dest_tag_o  out  PRF_IDX_W each  issued tags
iss_fu_sel_o  out  FU_SEL_W  issued FU select
iss_IR_o  out  32  issued instruction
iss_rob_idx_o  out  ROB_IDX_W  issued ROB index
iss_br_mask_o  out  BR_MASK_W  issued branch mask, corrected combinationally

Behaviour:
- Reset: iss_vld_r=0; all issue fields 0; fu_sel=FU_SEL_NONE; rr_ptr=0; ent_iss_en_o=0.
- ent_kill[i] = br_recovery_i & |(ent_br_mask[i] & br_tag_fix_i).
- cand[i] = ent_rdy_i[i] & ~ent_kill[i] & (ent_fu_sel[i] != FU_SEL_NONE).
- hold_kill = br_recovery_i & iss_vld_r & |(iss_br_mask_r & br_tag_fix_i).
- load_en = ~iss_vld_r | fu_rdy_i | hold_kill.
- Grant:
  - Lowest candidate index >= rr_ptr; if none, lowest candidate index < rr_ptr (wrap).
  - ent_iss_en_o is the one-hot grant when load_en and any cand; otherwise all zeros.
  - Grant is combinational in the same cycle; zero cycles from ent_rdy_i to ent_iss_en_o.
- rr_ptr: on a grant at index g, next rr_ptr = (g+1) mod RS_ENT_NUM; otherwise unchanged.
- Issue register, next state, in priority order:
  1. Grant: load the granted entry's fields; iss_vld_r=1.
  2. Else if load_en: iss_vld_r=0; fields cleared to reset values.
  3. Else hold: br_mask_r &= ~br_tag_fix_i when br_pred_correct_i.
- iss_vld_o = iss_vld_r & ~hold_kill. A killed instruction is never seen as valid, even in the cycle the kill arrives.
- iss_br_mask_o = br_pred_correct_i ? iss_br_mask_r & ~br_tag_fix_i : iss_br_mask_r.
- Latency: entry ready -> iss_vld_o is 1 cycle when the register is empty or draining. Throughput is 1 instruction/cycle while fu_rdy_i=1.
- Stall: when iss_vld_r=1 and fu_rdy_i=0 (and no kill):
  - no grant;
  - outputs stable, except iss_br_mask_o bit clearing.
- br_pred_correct_i and br_recovery_i both asserted is illegal upstream; if it occurs, recovery takes precedence and no mask bits are cleared.
- Recovery vs. empty register: recovery with no matching mask does not block issue.
- Reset mid-stall: the held instruction is dropped; rr_ptr returns to 0.

Decomposition:
- Shared package holds:
  - PRF_IDX_W, ROB_IDX_W, BR_MASK_W, FU_SEL_W;
  - FU_SEL_NONE;
  - an iss_pkt_t struct (opa, opb, dest, fu_sel, IR, rob_idx, br_mask) used for the issue register and the execute-stage input.
- Sub-module rr_arb(N): combinational round-robin picker with inputs req, ptr and outputs one-hot gnt, gnt_idx, any. Pointer storage stays in rs_iss_arb.

Test Plan:
- Reset, then ent_rdy_i=8'b0010_0100 with fu_rdy_i=1:
  - cycle 0 grants 8'b0000_0100; cycle 1 grants 8'b0010_0000;
  - iss_vld_o=1 from cycle 1; rr_ptr 3 then 6.
- rr_ptr=6, ent_rdy_i=8'b0000_0011 -> grant 8'b0000_0001 (wrap); rr_ptr becomes 1.
- iss_vld_r=1, fu_rdy_i=0 for 3 cycles, ent_rdy_i=8'hFF:
  - ent_iss_en_o=0 throughout and outputs stable;
  - fu_rdy_i=1 -> one grant the same cycle.
- Held br_mask=4'b0110, stalled, br_pred_correct_i=1, br_tag_fix_i=4'b0010 -> iss_br_mask_o=4'b0100 the same cycle and held thereafter.
- Held br_mask=4'b0100, stalled, br_recovery_i=1, br_tag_fix_i=4'b0100, entry 3 ready with mask 4'b0001:
  - iss_vld_o=0 the same cycle;
  - entry 3 granted; its instruction is valid the next cycle.
- br_recovery_i=1, tag 4'b1000; entry 0 ready with mask 4'b1000, entry 1 ready with mask 0 -> grant 8'b0000_0010 only.
